block_sequencer: RTL and testbench

BLOCK_SEQUENCER -- requirements
Module: block_sequencer

---
 rtl/sequencer_pkg.sv | 30 +++
 rtl/seq_timer.sv | 33 +++
 rtl/block_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_block_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// Shared types and constants for the block sequencer.
// Block geometry is fixed: one 64-bit block is two 32-bit words, high word first.
package sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_HI   = 4'd1,
    RD_HI_W = 4'd2,
    RD_LO   = 4'd3,
    RD_LO_W = 4'd4,
    CIPH    = 4'd5,
    WR_HI   = 4'd6,
    WR_LO   = 4'd7,
    NEXT    = 4'd8
  } seq_state_e;

  localparam logic [31:0] BLOCK_BYTES = 32'd8;
  localparam logic [31:0] WORD_OFFSET = 32'd4;

  // Byte address of the high or low word of block idx; wraps modulo 2^32.
  function automatic logic [31:0] block_addr(input logic [31:0] base,
                                             input logic [15:0] idx,
                                             input logic        lo_word);
    logic [31:0] addr;
    addr = base + ({16'd0, idx} * BLOCK_BYTES);
    addr = addr + (lo_word ? WORD_OFFSET : 32'd0);
    return addr;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Cycle counter that flags expiry after TIMEOUT_CYCLES enabled cycles.
// Cleared synchronously by clear; holds its count while disabled.
module seq_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count enabled cycles; expiry is seen during the TIMEOUT_CYCLES-th one.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable && !expired) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = enable && (cnt_r == LAST_CNT);

endmodule

// File: rtl/block_sequencer.sv
// Streams 64-bit blocks from memory through an external cipher core and back.
// Optional cipher watchdog: define CIPHER_TIMEOUT_EN to abort jobs whose core never answers.
module block_sequencer
  import sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  input  logic [15:0] num_blocks,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        cipher_start,
  output logic [63:0] cipher_in,
  input  logic        cipher_done,
  input  logic [63:0] cipher_out,
  output logic        busy,
  output logic        done,
  output logic        error
);

  seq_state_e  state_r, state_s;
  logic [31:0] src_r, src_s, dst_r, dst_s;
  logic [15:0] num_r, num_s, blk_r, blk_s;
  logic [63:0] cin_r, cin_s, res_r, res_s;
  logic        cipher_start_r, cipher_start_s;
  logic        done_r, done_s;
  logic        busy_r;
  logic        mem_req_r, mem_req_s, mem_write_r, mem_write_s;
  logic [31:0] mem_addr_r, mem_addr_s, mem_wdata_r, mem_wdata_s;
  logic        timer_en_s, timer_clr_s, timeout_s;

  // Next-state and job-context update.
  always_comb begin
    state_s        = state_r;
    src_s          = src_r;
    dst_s          = dst_r;
    num_s          = num_r;
    blk_s          = blk_r;
    cin_s          = cin_r;
    res_s          = res_r;
    cipher_start_s = 1'b0;
    done_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          src_s = src_addr;
          dst_s = dst_addr;
          num_s = num_blocks;
          blk_s = 16'd0;
          if (num_blocks == 16'd0) begin
            done_s = 1'b1;
          end else begin
            state_s = RD_HI;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_HI: begin
        if (mem_gnt) state_s = RD_HI_W;
        else         state_s = RD_HI;
      end
      RD_HI_W: begin
        if (mem_rvalid) begin
          cin_s[63:32] = mem_rdata;
          state_s      = RD_LO;
        end else begin
          state_s = RD_HI_W;
        end
      end
      RD_LO: begin
        if (mem_gnt) state_s = RD_LO_W;
        else         state_s = RD_LO;
      end
      RD_LO_W: begin
        if (mem_rvalid) begin
          cin_s[31:0]    = mem_rdata;
          cipher_start_s = 1'b1;
          state_s        = CIPH;
        end else begin
          state_s = RD_LO_W;
        end
      end
      CIPH: begin
        // A result arriving in the expiry cycle still wins over the watchdog.
        if (cipher_done) begin
          res_s   = cipher_out;
          state_s = WR_HI;
        end else if (timeout_s) begin
          state_s = IDLE;
        end else begin
          state_s = CIPH;
        end
      end
      WR_HI: begin
        if (mem_gnt) state_s = WR_LO;
        else         state_s = WR_HI;
      end
      WR_LO: begin
        if (mem_gnt) state_s = NEXT;
        else         state_s = WR_LO;
      end
      NEXT: begin
        if (({1'b0, blk_r} + 17'd1) < {1'b0, num_r}) begin
          blk_s   = blk_r + 16'd1;
          state_s = RD_HI;
        end else begin
          done_s  = 1'b1;
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Memory request fields are a pure function of the next state and job context,
  // so they stay constant for as long as a request is stalled.
  always_comb begin
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    mem_addr_s  = 32'd0;
    mem_wdata_s = 32'd0;
    case (state_s)
      RD_HI: begin
        mem_req_s  = 1'b1;
        mem_addr_s = block_addr(src_s, blk_s, 1'b0);
      end
      RD_LO: begin
        mem_req_s  = 1'b1;
        mem_addr_s = block_addr(src_s, blk_s, 1'b1);
      end
      WR_HI: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        mem_addr_s  = block_addr(dst_s, blk_s, 1'b0);
        mem_wdata_s = res_s[63:32];
      end
      WR_LO: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        mem_addr_s  = block_addr(dst_s, blk_s, 1'b1);
        mem_wdata_s = res_s[31:0];
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // State and job-context registers.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_r <= IDLE;
      src_r   <= 32'd0;
      dst_r   <= 32'd0;
      num_r   <= 16'd0;
      blk_r   <= 16'd0;
      cin_r   <= 64'd0;
      res_r   <= 64'd0;
    end else begin
      state_r <= state_s;
      src_r   <= src_s;
      dst_r   <= dst_s;
      num_r   <= num_s;
      blk_r   <= blk_s;
      cin_r   <= cin_s;
      res_r   <= res_s;
    end
  end

  // Output registers; all clear the instant reset asserts.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      mem_req_r      <= 1'b0;
      mem_write_r    <= 1'b0;
      mem_addr_r     <= 32'd0;
      mem_wdata_r    <= 32'd0;
      cipher_start_r <= 1'b0;
      done_r         <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      mem_req_r      <= mem_req_s;
      mem_write_r    <= mem_write_s;
      mem_addr_r     <= mem_addr_s;
      mem_wdata_r    <= mem_wdata_s;
      cipher_start_r <= cipher_start_s;
      done_r         <= done_s;
      busy_r         <= (state_s != IDLE);
    end
  end

`ifdef CIPHER_TIMEOUT_EN
  logic error_r;

  assign timer_en_s = (state_r == CIPH);

  // Sticky abort flag; a newly accepted job starts clean.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      error_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      error_r <= 1'b0;
    end else if ((state_r == CIPH) && !cipher_done && timeout_s) begin
      error_r <= 1'b1;
    end else begin
      error_r <= error_r;
    end
  end

  assign error = error_r;
`else
  assign timer_en_s = 1'b0;
  assign error      = 1'b0;
`endif

  assign timer_clr_s = (state_r != CIPH);

  seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .enable (timer_en_s),
    .clear  (timer_clr_s),
    .expired(timeout_s)
  );

  assign mem_req      = mem_req_r;
  assign mem_write    = mem_write_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign cipher_start = cipher_start_r;
  assign cipher_in    = cin_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_block_sequencer.sv
// Self-checking bench for block_sequencer: memory and cipher responders plus a
// transaction-level reference of what each job must read, launch and write.
`timescale 1ns/1ps
module tb_block_sequencer;

  localparam int unsigned TO = 255;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] num_blocks;
  logic        mem_req, mem_write, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        cipher_start, cipher_done;
  logic [63:0] cipher_in, cipher_out;
  logic        busy, done, error;

  block_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .num_blocks(num_blocks), .mem_req(mem_req),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .cipher_start(cipher_start), .cipher_in(cipher_in), .cipher_done(cipher_done),
    .cipher_out(cipher_out), .busy(busy), .done(done), .error(error)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  txn_t        obs_q[$];
  logic [95:0] stall_held_q[$], stall_now_q[$];
  logic [63:0] cin_seen_q[$], hold_exp_q[$], hold_now_q[$];
  int          gnt_delay = 0, rv_max = 0, stall_cnt = 0, rv_cnt = -1, cd_cnt = -1;
  int          cstart_cnt = 0, done_cnt = 0;
  bit          noise_en = 1'b0, cipher_mute = 1'b0;
  logic [95:0] held_req;
  logic [31:0] rv_data;
  logic [63:0] cin_held;

  function automatic logic [63:0] core_f(input logic [63:0] x);
    return {x[31:0], x[63:32]} ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: grants after gnt_delay stalled cycles, returns read data 1+rv_cnt cycles later.
  always @(negedge HCLK) begin
    txn_t t;
    if (!HRESET) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; stall_cnt = 0; rv_cnt = -1;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1; mem_rdata = rv_data; rv_cnt = -1;
      end else if (rv_cnt > 0) begin
        rv_cnt = rv_cnt - 1;
      end else if (noise_en && ($urandom_range(0, 3) == 0)) begin
        mem_rvalid = 1'b1;
      end
      mem_gnt = 1'b0;
      if (mem_req) begin
        if (stall_cnt == 0) begin
          held_req = {31'd0, mem_write, mem_addr, mem_wdata};
        end else begin
          stall_held_q.push_back(held_req);
          stall_now_q.push_back({31'd0, mem_write, mem_addr, mem_wdata});
        end
        if (stall_cnt >= gnt_delay) begin
          mem_gnt = 1'b1; stall_cnt = 0;
          t.w = mem_write; t.a = mem_addr; t.d = mem_write ? mem_wdata : 32'd0;
          obs_q.push_back(t);
          if (!mem_write) begin
            rv_data = mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_BEEF;
            rv_cnt  = int'($urandom_range(0, rv_max));
          end
        end else begin
          stall_cnt = stall_cnt + 1;
        end
      end
    end
  end

  // Cipher core: answers core_f(cipher_in) 0..3 cycles after cipher_start unless muted.
  always @(negedge HCLK) begin
    if (!HRESET) begin
      cipher_done = 1'b0; cipher_out = 64'd0; cd_cnt = -1;
    end else begin
      cipher_done = 1'b0;
      cipher_out  = {$urandom, $urandom};
      if (cipher_start) begin
        cstart_cnt = cstart_cnt + 1;
        cin_seen_q.push_back(cipher_in);
        cin_held = cipher_in;
        cd_cnt   = cipher_mute ? -1 : int'($urandom_range(0, 3));
      end else if (cd_cnt >= 0) begin
        hold_exp_q.push_back(cin_held);
        hold_now_q.push_back(cipher_in);
      end
      if (cd_cnt == 0) begin
        cipher_done = 1'b1; cipher_out = core_f(cin_held); cd_cnt = -1;
      end else if (cd_cnt > 0) begin
        cd_cnt = cd_cnt - 1;
      end else if (noise_en && !cipher_start && ($urandom_range(0, 3) == 0)) begin
        cipher_done = 1'b1;
      end
    end
  end

  always @(negedge HCLK) begin
    if (done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic step();
    @(negedge HCLK);
    #1;
  endtask

  task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int n,
                         input int gd, input bit poke);
    txn_t        exp_q[$];
    logic [63:0] blk_q[$];
    txn_t        t;
    logic [31:0] a;
    logic [63:0] b, r;
    int          ob0, cb0, sb0, hb0, cs0, d0, cyc;
    gnt_delay = gd;
    for (int i = 0; i < n; i++) begin
      a = src + 32'(i) * 32'd8;
      mem[a] = $urandom;
      mem[a + 32'd4] = $urandom;
      b = {mem[a], mem[a + 32'd4]};
      r = core_f(b);
      blk_q.push_back(b);
      t.w = 1'b0; t.a = a;          t.d = 32'd0;    exp_q.push_back(t);
      t.a = a + 32'd4;                               exp_q.push_back(t);
      t.w = 1'b1; t.a = dst + 32'(i) * 32'd8; t.d = r[63:32]; exp_q.push_back(t);
      t.a = t.a + 32'd4;           t.d = r[31:0];  exp_q.push_back(t);
    end
    ob0 = obs_q.size(); cb0 = cin_seen_q.size(); sb0 = stall_now_q.size();
    hb0 = hold_now_q.size(); cs0 = cstart_cnt; d0 = done_cnt;
    src_addr = src; dst_addr = dst; num_blocks = 16'(n); start = 1'b1;
    step();
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; num_blocks = 16'($urandom);
    check("done_first_cycle", done, (n == 0));
    check("busy_first_cycle", busy, (n != 0));
    cyc = 0;
    while (done_cnt == d0 && cyc < 2000) begin
      start = poke && (cyc == 4);
      step();
      cyc++;
    end
    start = 1'b0;
    check("job_completed", (done_cnt != d0), 1);
    repeat (3) step();
    check("done_pulses", done_cnt - d0, 1);
    check("busy_idle", busy, 0);
    check("mem_req_idle", mem_req, 0);
    check("error_flag", error, 0);
    check("txn_count", obs_q.size() - ob0, exp_q.size());
    for (int k = 0; k < exp_q.size() && (ob0 + k) < obs_q.size(); k++)
      check($sformatf("txn%0d", k),
            {31'd0, obs_q[ob0 + k].w, obs_q[ob0 + k].a, obs_q[ob0 + k].d},
            {31'd0, exp_q[k].w, exp_q[k].a, exp_q[k].d});
    check("cipher_starts", cstart_cnt - cs0, n);
    for (int k = 0; k < n && (cb0 + k) < cin_seen_q.size(); k++)
      check($sformatf("cipher_in%0d", k), cin_seen_q[cb0 + k], blk_q[k]);
    for (int k = sb0; k < stall_now_q.size(); k++)
      check("req_stable", stall_now_q[k], stall_held_q[k]);
    for (int k = hb0; k < hold_now_q.size(); k++)
      check("cipher_in_stable", hold_now_q[k], hold_exp_q[k]);
    check("stall_cycles", stall_now_q.size() - sb0, exp_q.size() * gd);
  endtask

  initial begin
    bit found;
    int k;
    start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; num_blocks = 16'd0; HRESET = 1'b0;
    repeat (2) step();
    check("rst_mem_req", mem_req, 0);
    check("rst_cipher_start", cipher_start, 0);
    check("rst_cipher_in", cipher_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    HRESET = 1'b1;
    step();

    rv_max = 0;
    run_job(32'h0000_1000, 32'h0000_2000, 1, 0, 1'b0);
    check("n1_first_read", obs_q[0].a, 32'h0000_1000);
    check("n1_last_write", obs_q[3].a, 32'h0000_2004);
    run_job(32'h0000_4000, 32'h0000_5000, 3, 2, 1'b1);
    run_job(32'h0000_8000, 32'h0000_9000, 0, 0, 1'b0);
    k = obs_q.size();
    run_job(32'hFFFF_FFF8, 32'h0000_3000, 2, 1, 1'b0);
    check("wrap_rd_hi", obs_q[k + 4].a, 32'h0000_0000);
    check("wrap_rd_lo", obs_q[k + 5].a, 32'h0000_0004);

    noise_en = 1'b1; rv_max = 2;
    for (int j = 0; j < 6; j++)
      run_job($urandom, $urandom, int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), (j % 2 == 1));
    noise_en = 1'b0;

    // Reset while a write is stalled in WR_HI.
    gnt_delay = 3;
    src_addr = 32'h0000_6000; dst_addr = 32'h0000_7000; num_blocks = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      if (mem_req && mem_write) found = 1'b1;
    end
    check("reached_wr_hi", found, 1);
    #1 HRESET = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_mem_write", mem_write, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wdata", mem_wdata, 0);
    check("midrst_cipher_in", cipher_in, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    step();
    HRESET = 1'b1;
    repeat (3) step();
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_req", mem_req, 0);
    run_job(32'h0000_A000, 32'h0000_B000, 2, 1, 1'b0);

`ifdef CIPHER_TIMEOUT_EN
    begin
      int cs0, d0, cyc;
      cipher_mute = 1'b1; gnt_delay = 0;
      cs0 = cstart_cnt; d0 = done_cnt;
      src_addr = 32'h0000_C000; dst_addr = 32'h0000_D000; num_blocks = 16'd1; start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (cstart_cnt == cs0 && cyc < 100) begin step(); cyc++; end
      check("to_cipher_started", cstart_cnt - cs0, 1);
      cyc = 0;
      while (error !== 1'b1 && cyc < 600) begin step(); cyc++; end
      check("to_cycles", cyc, TO);
      check("to_no_done", done_cnt - d0, 0);
      check("to_busy", busy, 0);
      cipher_mute = 1'b0;
      run_job(32'h0000_E000, 32'h0000_F000, 0, 0, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
